// File: rtl/lcd_resultado.sv
// Shows the calculator result (sign + 16-bit magnitude) on line 2 of an HD44780-style LCD.
// Runs the power-up init, converts with a serial double-dabble and rewrites only when the value changes.
module lcd_resultado #(
    parameter int INIT_WAIT  = 750000,
    parameter int EN_CYCLES  = 25,
    parameter int CMD_WAIT   = 2500,
    parameter int CLEAR_WAIT = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] saida,
    input  logic        sinal_saida,
    output logic [7:0]  data,
    output logic        EN,
    output logic        RS,
    output logic        RW,
    output logic        busy
);

    localparam int MAX_A   = (INIT_WAIT > CLEAR_WAIT) ? INIT_WAIT : CLEAR_WAIT;
    localparam int MAX_B   = (CMD_WAIT > EN_CYCLES) ? CMD_WAIT : EN_CYCLES;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_MAX = (MAX_C > 16) ? MAX_C : 16;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, CONV, WRITE} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} phase_t;

    state_t             state_q, state_n;
    phase_t             phase_q, phase_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [2:0]         idx_q, idx_n;
    logic               valid_q;
    logic [7:0]         data_q;
    logic               rs_q;

    logic [15:0]        mag_q, bin_q;
    logic               sign_q;
    logic [19:0]        bcd_q;
    logic [16:0]        last_q;

    logic               capture, conv_en, commit, sending, last_byte;
    logic [7:0]         cur_byte;
    logic               cur_rs;
    logic [CNT_W-1:0]   wait_last;
    logic               z4, z3, z2, z1;
    logic [15:0]        bcd_adj;

    // Add 3 to every BCD digit >= 5 ahead of the shift; the top digit never reaches 5 before
    // its final shift for a 16-bit input, so only the lower four digits need adjusting.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] d, input logic blank);
        return blank ? 8'h20 : (8'h30 + {4'h0, d});
    endfunction

    assign bcd_adj   = bcd_adjust(bcd_q[15:0]);
    assign sending   = (state_q == INIT) || (state_q == WRITE);
    assign last_byte = (state_q == INIT) ? (idx_q == 3'd3) : (idx_q == 3'd6);
    assign wait_last = (state_q == INIT && idx_q == 3'd3) ? CNT_W'(CLEAR_WAIT - 1)
                                                          : CNT_W'(CMD_WAIT - 1);

    always_comb begin
        cur_byte = 8'h00;
        cur_rs   = 1'b0;
        z4 = (bcd_q[19:16] == 4'd0);
        z3 = z4 && (bcd_q[15:12] == 4'd0);
        z2 = z3 && (bcd_q[11:8] == 4'd0);
        z1 = z2 && (bcd_q[7:4] == 4'd0);
        if (state_q == INIT) begin
            case (idx_q)
                3'd0:    cur_byte = 8'h38;
                3'd1:    cur_byte = 8'h0C;
                3'd2:    cur_byte = 8'h06;
                default: cur_byte = 8'h01;
            endcase
        end else if (state_q == WRITE) begin
            cur_rs = (idx_q != 3'd0);
            case (idx_q)
                3'd0:    cur_byte = 8'hC0;
                3'd1:    cur_byte = (sign_q && mag_q != 16'd0) ? 8'h2D : 8'h20;
                3'd2:    cur_byte = digit_char(bcd_q[19:16], z4);
                3'd3:    cur_byte = digit_char(bcd_q[15:12], z3);
                3'd4:    cur_byte = digit_char(bcd_q[11:8], z2);
                3'd5:    cur_byte = digit_char(bcd_q[7:4], z1);
                default: cur_byte = digit_char(bcd_q[3:0], 1'b0);
            endcase
        end
    end

    always_comb begin
        state_n = state_q;
        phase_n = phase_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        capture = 1'b0;
        conv_en = 1'b0;
        commit  = 1'b0;
        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == CNT_W'(INIT_WAIT - 1)) begin
                    state_n = INIT;
                    phase_n = PH_SETUP;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            INIT, WRITE: begin
                case (phase_q)
                    PH_SETUP: begin
                        phase_n = PH_EN;
                        cnt_n   = '0;
                    end
                    PH_EN: begin
                        if (cnt_q == CNT_W'(EN_CYCLES - 1)) begin
                            phase_n = PH_WAIT;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        if (cnt_q == wait_last) begin
                            phase_n = PH_SETUP;
                            cnt_n   = '0;
                            if (last_byte) begin
                                state_n = IDLE;
                                commit  = (state_q == WRITE);
                            end else begin
                                idx_n = idx_q + 3'd1;
                            end
                        end else begin
                            cnt_n = cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
            IDLE: begin
                if (!valid_q || ({sinal_saida, saida} != last_q)) begin
                    capture = 1'b1;
                    state_n = CONV;
                    cnt_n   = '0;
                end
            end
            CONV: begin
                conv_en = 1'b1;
                if (cnt_q == CNT_W'(15)) begin
                    state_n = WRITE;
                    phase_n = PH_SETUP;
                    idx_n   = '0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: state_n = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PWR_WAIT;
            phase_q <= PH_SETUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            phase_q <= phase_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            valid_q <= valid_q | commit;
            if (sending) begin
                data_q <= cur_byte;
                rs_q   <= cur_rs;
            end
        end
    end

    // Datapath registers carry no reset; they are loaded on capture before any use.
    always_ff @(posedge clk) begin
        if (capture) begin
            mag_q  <= saida;
            sign_q <= sinal_saida;
            bin_q  <= saida;
            bcd_q  <= '0;
        end else if (conv_en) begin
            bcd_q <= {bcd_q[18:16], bcd_adj, bin_q[15]};
            bin_q <= {bin_q[14:0], 1'b0};
        end
        if (commit)
            last_q <= {sign_q, mag_q};
    end

    assign EN   = sending && (phase_q == PH_EN);
    assign data = sending ? cur_byte : data_q;
    assign RS   = sending ? cur_rs : rs_q;
    assign RW   = 1'b0;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_resultado.sv
// Scoreboard bench for lcd_resultado: expected LCD bytes are queued from a decimal model,
// and a monitor decodes each byte on the EN falling edge and checks strobe width and spacing.
module tb_lcd_resultado;

    localparam int IW  = 20;
    localparam int EC  = 2;
    localparam int CW  = 5;
    localparam int CLW = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] saida = 16'd0;
    logic        sinal = 1'b0;
    logic [7:0]  data;
    logic        EN, RS, RW, busy;

    always #5 clk = ~clk;

    lcd_resultado #(
        .INIT_WAIT (IW),
        .EN_CYCLES (EC),
        .CMD_WAIT  (CW),
        .CLEAR_WAIT(CLW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .saida      (saida),
        .sinal_saida(sinal),
        .data       (data),
        .EN         (EN),
        .RS         (RS),
        .RW         (RW),
        .busy       (busy)
    );

    typedef struct {
        logic [8:0] b;
        int         gap;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          pulses = 0;
    logic [16:0] model_last;
    bit          model_valid = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [8:0] b, input int gap);
        exp_t e;
        e.b   = b;
        e.gap = gap;
        q.push_back(e);
    endtask

    task automatic push_init();
        push({1'b0, 8'h38}, IW);
        push({1'b0, 8'h0C}, CW + 1);
        push({1'b0, 8'h06}, CW + 1);
        push({1'b0, 8'h01}, CW + 1);
    endtask

    // Reference: plain decimal digits, blank leading zeros, minus only for nonzero negatives.
    task automatic push_value(input logic [15:0] m, input logic s);
        int d[5];
        int v;
        bit lead;
        v = int'(m);
        for (int i = 0; i < 5; i++) begin
            d[i] = v % 10;
            v = v / 10;
        end
        push({1'b0, 8'hC0}, 0);
        push({1'b1, (s && m != 0) ? 8'h2D : 8'h20}, CW + 1);
        lead = 1;
        for (int i = 4; i >= 0; i--) begin
            if (lead && d[i] == 0 && i != 0) begin
                push({1'b1, 8'h20}, CW + 1);
            end else begin
                lead = 0;
                push({1'b1, 8'(8'h30 + d[i])}, CW + 1);
            end
        end
    endtask

    task automatic apply(input logic [15:0] m, input logic s);
        saida = m;
        sinal = s;
        if (!model_valid || {s, m} != model_last) begin
            push_value(m, s);
            model_last  = {s, m};
            model_valid = 1;
        end
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (q.size() == 0 && busy === 1'b0) break;
        end
        check({name, "_idle"}, int'(busy), 0);
        check({name, "_queue"}, q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_EN"}, int'(EN), 0);
        check({name, "_data"}, int'(data), 0);
        check({name, "_RS"}, int'(RS), 0);
        check({name, "_RW"}, int'(RW), 0);
        check({name, "_busy"}, int'(busy), 1);
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        q.delete();
        model_valid = 0;
        #1;
        check_reset_outputs(name);
        repeat (3) @(negedge clk);
        push_init();
        apply(saida, sinal);
        rst_n = 1'b1;
    endtask

    // Monitor: sampled 1 time unit after each rising edge.
    initial begin
        bit         en_prev;
        bit         busy_prev;
        bit         seen;
        int         hi_cnt;
        int         lo_cnt;
        logic [8:0] last_b;
        exp_t       e;
        en_prev = 0; busy_prev = 1; seen = 0; hi_cnt = 0; lo_cnt = 0; last_b = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                en_prev = 0; busy_prev = 1; seen = 0; hi_cnt = 0; lo_cnt = 0;
            end else begin
                if (busy_prev && !busy && seen)
                    check("busy_fall_wait", lo_cnt, (last_b == {1'b0, 8'h01}) ? CLW : CW);
                busy_prev = busy;
                if (EN) begin
                    if (!en_prev && q.size() > 0 && q[0].gap != 0)
                        check("gap_before_byte", lo_cnt, q[0].gap);
                    hi_cnt++;
                end else begin
                    if (en_prev) begin
                        pulses++;
                        check("en_width", hi_cnt, EC);
                        if (q.size() == 0) begin
                            check("unexpected_byte", int'({RS, data}), 0);
                        end else begin
                            e = q.pop_front();
                            check("byte", int'({RS, data}), int'(e.b));
                        end
                        last_b = {RS, data};
                        seen   = 1;
                        hi_cnt = 0;
                        lo_cnt = 0;
                    end
                    lo_cnt++;
                end
                en_prev = EN;
            end
        end
    end

    initial begin
        int         p0;
        int         rises;
        bit         en_p;
        logic [15:0] rm;
        logic        rs;
        saida = 16'd1234;
        sinal = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        push_init();
        apply(16'd1234, 1'b0);
        rst_n = 1'b1;
        wait_done("init_1234");

        apply(16'd65535, 1'b1);
        wait_done("max_neg");

        apply(16'd0, 1'b1);
        wait_done("neg_zero");
        p0 = pulses;
        repeat (1000) @(negedge clk);
        check("quiet_pulses", pulses - p0, 0);

        apply(16'd7, 1'b0);
        rises = 0;
        en_p  = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (EN && !en_p) rises++;
            en_p = EN;
            if (rises == 3) break;
        end
        check("third_byte_reached", rises, 3);
        apply(16'd500, 1'b0);
        wait_done("change_mid_write");

        apply(16'd0, 1'b0);
        wait_done("pos_zero");
        apply(16'd10000, 1'b1);
        wait_done("ten_thousand");
        apply(16'd9, 1'b1);
        wait_done("single_digit");

        for (int k = 0; k < 8; k++) begin
            rm = 16'($urandom_range(65535, 0));
            rs = 1'($urandom_range(1, 0));
            apply(rm, rs);
            wait_done("random");
        end

        apply(16'd4321, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (EN) break;
        end
        check("en_high_before_reset", int'(EN), 1);
        do_reset("reset_mid_byte");
        wait_done("after_reset_mid_byte");

        apply(16'd808, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        check("busy_enter_conv", int'(busy), 1);
        repeat (3) @(negedge clk);
        do_reset("reset_in_conv");
        wait_done("after_reset_in_conv");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
